// File: rtl/bkm_csd_pkg.sv
// Shared definitions for the CSD (canonic signed digit) datapath blocks.
// Digit pair encoding is {s,d} with value d - s; 2'b11 is never produced.
package bkm_csd_pkg;

  localparam logic [1:0] CSD_ZERO = 2'b00;
  localparam logic [1:0] CSD_POS  = 2'b01;
  localparam logic [1:0] CSD_NEG  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } csd_state_e;

endpackage

// File: rtl/bin2csd_cell.sv
// One Reitwiesner recoding step: given bit x_i, lookahead bit x_{i+1} and the
// incoming carry c_i, produce CSD digit i and carry c_{i+1}.
//   c_{i+1} = floor((x_i + x_{i+1} + c_i) / 2)   (majority of the three bits)
//   digit_i = x_i + c_i - 2*c_{i+1}
// The digit is nonzero exactly when x_i ^ c_i; its sign is then set by c_{i+1}.
module bin2csd_cell
  import bkm_csd_pkg::*;
(
  input  logic       x_i,
  input  logic       x_ip1,
  input  logic       c_i,
  output logic [1:0] digit,
  output logic       c_o
);

  logic odd;

  assign odd = x_i ^ c_i;
  assign c_o = (x_i & x_ip1) | (x_i & c_i) | (x_ip1 & c_i);

  // Select the digit code from parity and outgoing carry.
  always_comb begin
    digit = CSD_ZERO;
    if (odd) digit = c_o ? CSD_NEG : CSD_POS;
  end

endmodule

// File: rtl/bin2csd_ser.sv
// Sequential two's-complement to CSD converter, R digits per clock.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; in_ready and out_valid are registers, and x is sampled only at
// the input transfer while y stays constant for the whole of DONE.
// Optional feature: define BIN2CSD_NZ_COUNT_EN to add port nz, the number of
// nonzero digits in y (valid with out_valid).
module bin2csd_ser
  import bkm_csd_pkg::*;
#(
  parameter int W = 64,
  parameter int R = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*W-1:0]           y,
`ifdef BIN2CSD_NZ_COUNT_EN
  output logic [$clog2(W+1)-1:0]   nz,
`endif
  output logic [1:0]               dbg_state
);

  localparam int STEPS = W / R;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (R < 1 || R > W || (W % R) != 0) begin : g_bad_params
    $error("bin2csd_ser: R must divide W and satisfy 1 <= R <= W");
  end

  csd_state_e     state;
  logic [W-1:0]   xs;
  logic           carry;
  logic [CW-1:0]  cnt;

  // xs_ext[W] is the sign copy, so the last cell of the final chunk sees x_W.
  logic [W:0]     xs_ext;
  logic [R:0]     cc;
  logic [2*R-1:0] chunk;
  logic [2*W-1:0] chunk_wide;
  logic [2*W-1:0] y_next;
  logic [W-1:0]   xs_next;

  assign xs_ext     = {xs[W-1], xs};
  assign cc[0]      = carry;
  assign chunk_wide = (2*W)'(chunk);
  assign y_next     = (y >> (2*R)) | (chunk_wide << (2*(W-R)));
  assign xs_next    = W'($signed(xs) >>> R);
  assign dbg_state  = state;

  for (genvar j = 0; j < R; j++) begin : g_cell
    bin2csd_cell u_cell (
      .x_i   (xs_ext[j]),
      .x_ip1 (xs_ext[j+1]),
      .c_i   (cc[j]),
      .digit (chunk[2*j +: 2]),
      .c_o   (cc[j+1])
    );
  end

  // Control FSM plus the operand/result shift registers and carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      xs        <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xs       <= x;
            carry    <= 1'b0;
            cnt      <= '0;
            y        <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          xs    <= xs_next;
          y     <= y_next;
          carry <= cc[R];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BIN2CSD_NZ_COUNT_EN
  localparam int NZW = $clog2(W + 1);
  localparam int NZC = $clog2(R + 1);

  logic [NZC-1:0] chunk_nz;

  // Count the nonzero digits produced by this cycle's chunk.
  always_comb begin
    chunk_nz = '0;
    for (int j = 0; j < R; j++) begin
      chunk_nz = chunk_nz + NZC'(chunk[2*j +: 2] != CSD_ZERO);
    end
  end

  // Accumulate the nonzero-digit count across the BUSY cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nz <= '0;
    end else if (state == IDLE && in_valid) begin
      nz <= '0;
    end else if (state == BUSY) begin
      nz <= nz + NZW'(chunk_nz);
    end
  end
`endif

endmodule

// File: tb/tb_bin2csd_ser.sv
// Bench for bin2csd_ser: directed W=8/R=2 vectors, backpressure and
// mid-conversion reset sequences, and property checks on W=64 instances
// with R = 1, 4 and 64.
module tb_bin2csd_ser;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  // ---------------- narrow DUT (W=8, R=2) ----------------
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  x;
  logic [15:0] y;
  logic [1:0]  st;
`ifdef BIN2CSD_NZ_COUNT_EN
  logic [3:0]  nz;
`endif

  bin2csd_ser #(.W(8), .R(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
`ifdef BIN2CSD_NZ_COUNT_EN
    .nz        (nz),
`endif
    .dbg_state (st)
  );

  // ---------------- wide DUTs (W=64, R=1/4/64) ----------------
  logic         w_in_valid, w_out_ready;
  logic [63:0]  w_x;
  logic         w_in_ready  [3];
  logic         w_out_valid [3];
  logic [127:0] w_y         [3];
  logic [1:0]   w_st        [3];
`ifdef BIN2CSD_NZ_COUNT_EN
  logic [6:0]   w_nz        [3];
`endif

  for (genvar gi = 0; gi < 3; gi++) begin : g_wide
    localparam int RR = (gi == 0) ? 1 : ((gi == 1) ? 4 : 64);
    bin2csd_ser #(.W(64), .R(RR)) u_w (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w_in_valid),
      .in_ready  (w_in_ready[gi]),
      .x         (w_x),
      .out_valid (w_out_valid[gi]),
      .out_ready (w_out_ready),
      .y         (w_y[gi]),
`ifdef BIN2CSD_NZ_COUNT_EN
      .nz        (w_nz[gi]),
`endif
      .dbg_state (w_st[gi])
    );
  end

  // ---------------- scoreboard helpers ----------------
  logic [127:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- narrow driver tasks ----------------
  task automatic main_accept(input logic [7:0] xv);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", in_ready, 1);
    x        = xv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x        = 8'($urandom);
  endtask

  task automatic main_wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic main_release();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- wide property helpers ----------------
  function automatic logic signed [65:0] csd_value(input logic [127:0] yv);
    logic signed [65:0] acc;
    logic signed [65:0] p;
    acc = '0;
    for (int i = 0; i < 64; i++) begin
      p = 66'sd1 <<< i;
      if (yv[2*i +: 2] == 2'b01) acc = acc + p;
      else if (yv[2*i +: 2] == 2'b10) acc = acc - p;
    end
    return acc;
  endfunction

  function automatic int count_code11(input logic [127:0] yv);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) if (yv[2*i +: 2] == 2'b11) n++;
    return n;
  endfunction

  function automatic int count_adjacent(input logic [127:0] yv);
    int n;
    n = 0;
    for (int i = 0; i < 63; i++)
      if (yv[2*i +: 2] != 2'b00 && yv[2*i+2 +: 2] != 2'b00) n++;
    return n;
  endfunction

  function automatic int count_nonzero(input logic [127:0] yv);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) if (yv[2*i +: 2] != 2'b00) n++;
    return n;
  endfunction

  task automatic wide_run(input logic [63:0] xv);
    int           n;
    logic [2:0]   got;
    logic [127:0] ys  [3];
    int           nzs [3];
    logic signed [65:0] sx;
    n = 0;
    while (!(w_in_ready[0] && w_in_ready[1] && w_in_ready[2]) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("wide_accept_ready", {w_in_ready[0], w_in_ready[1], w_in_ready[2]}, 3'b111);
    w_x        = xv;
    w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    w_x        = {$urandom, $urandom};
    got = '0;
    n   = 0;
    while (got != 3'b111 && n < 200) begin
      for (int k = 0; k < 3; k++) begin
        if (w_out_valid[k] && !got[k]) begin
          got[k] = 1'b1;
          ys[k]  = w_y[k];
`ifdef BIN2CSD_NZ_COUNT_EN
          nzs[k] = int'(w_nz[k]);
`else
          nzs[k] = 0;
`endif
        end
      end
      if (got != 3'b111) begin
        @(posedge clk); #1; n++;
      end
    end
    check("wide_done", got, 3'b111);
    sx = $signed({xv[63], xv[63], xv});
    for (int k = 0; k < 3; k++) begin
      if (got[k]) begin
        exp_q.push_back(128'(sx));
        check($sformatf("roundtrip_r%0d x=%0h", k, xv), 128'(csd_value(ys[k])), exp_q.pop_front());
        check($sformatf("code11_r%0d", k), count_code11(ys[k]), 0);
        check($sformatf("adjacent_r%0d", k), count_adjacent(ys[k]), 0);
`ifdef BIN2CSD_NZ_COUNT_EN
        check($sformatf("nz_r%0d", k), nzs[k], count_nonzero(ys[k]));
`endif
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0]  x;
    logic [15:0] y;
    int          nz;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;

    vecs[0] = '{x: 8'h00, y: 16'h0000, nz: 0};
    vecs[1] = '{x: 8'h07, y: 16'h0042, nz: 2};  // +8 -1
    vecs[2] = '{x: 8'hFF, y: 16'h0002, nz: 1};  // -1
    vecs[3] = '{x: 8'h80, y: 16'h8000, nz: 1};  // -128
    vecs[4] = '{x: 8'h55, y: 16'h1111, nz: 4};  // +64 +16 +4 +1
    vecs[5] = '{x: 8'hAA, y: 16'h8444, nz: 4};  // -128 +32 +8 +2 = -86
    vecs[6] = '{x: 8'h7F, y: 16'h4002, nz: 2};  // +128 -1 = 127
    vecs[7] = '{x: 8'h01, y: 16'h0001, nz: 1};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    x           = '0;
    w_in_valid  = 1'b0;
    w_out_ready = 1'b1;
    w_x         = '0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_state", st, 0);
`ifdef BIN2CSD_NZ_COUNT_EN
    check("rst_nz", nz, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table-driven conversions
    for (int i = 0; i < 8; i++) begin
      main_accept(vecs[i].x);
      check($sformatf("busy_in_ready x=%0h", vecs[i].x), in_ready, 0);
      main_wait_done(lat);
      check($sformatf("latency x=%0h", vecs[i].x), lat, 4);
      check($sformatf("y x=%0h", vecs[i].x), y, vecs[i].y);
`ifdef BIN2CSD_NZ_COUNT_EN
      check($sformatf("nz x=%0h", vecs[i].x), nz, vecs[i].nz);
`endif
      main_release();
      check($sformatf("release_out_valid x=%0h", vecs[i].x), out_valid, 0);
      @(posedge clk); #1;
      check($sformatf("release_in_ready x=%0h", vecs[i].x), in_ready, 1);
    end

    // backpressure: hold DONE, a second in_valid must be ignored
    main_accept(8'h55);
    main_wait_done(lat);
    check("bp_latency", lat, 4);
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 2);
      x        = 8'h07;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("bp_y c=%0d", c), y, 16'h1111);
      check($sformatf("bp_out_valid c=%0d", c), out_valid, 1);
      check($sformatf("bp_in_ready c=%0d", c), in_ready, 0);
    end
    main_release();
    check("bp_after_out_valid", out_valid, 0);
    check("bp_after_in_ready", in_ready, 1);
    check("bp_after_state", st, 0);
    main_accept(8'h07);
    main_wait_done(lat);
    check("bp_next_latency", lat, 4);
    check("bp_next_y", y, 16'h0042);
    main_release();

    // reset during the second BUSY cycle
    main_accept(8'hFF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_y", y, 0);
    check("midrst_state", st, 0);
`ifdef BIN2CSD_NZ_COUNT_EN
    check("midrst_nz", nz, 0);
`endif
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_output", out_valid, 0);
    main_accept(8'h07);
    main_wait_done(lat);
    check("midrst_next_latency", lat, 4);
    check("midrst_next_y", y, 16'h0042);
    main_release();

    // wide instances: boundary operands, then random ones
    wide_run(64'h0);
    wide_run(64'hFFFF_FFFF_FFFF_FFFF);
    wide_run(64'h8000_0000_0000_0000);
    wide_run(64'h7FFF_FFFF_FFFF_FFFF);
    wide_run(64'h5555_5555_5555_5555);
    wide_run(64'hAAAA_AAAA_AAAA_AAAA);
    for (int i = 0; i < 300; i++) begin
      wide_run({$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
